// File: rtl/parking_slot_manager_if.sv
// rtl/parking_slot_manager_if.sv - sensor requests and status outputs of the parking slot manager
interface parking_slot_manager_if #(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 4,
    parameter int TIMER_W   = 16
);
    logic                 entry_sensor_n;
    logic                 exit_sensor_n;
    logic [SLOT_W-1:0]    exit_slot;
    logic [NUM_SLOTS-1:0] occupied;
    logic [SLOT_W:0]      free_count;
    logic [SLOT_W-1:0]    next_slot;
    logic                 full_light;
    logic                 door_light;
    logic                 show_time;
    logic [TIMER_W-1:0]   exit_minutes;
    logic [SLOT_W-1:0]    shown_slot;
    logic                 exit_err;

    modport master (
        output entry_sensor_n, exit_sensor_n, exit_slot,
        input  occupied, free_count, next_slot, full_light, door_light,
               show_time, exit_minutes, shown_slot, exit_err
    );

    modport slave (
        input  entry_sensor_n, exit_sensor_n, exit_slot,
        output occupied, free_count, next_slot, full_light, door_light,
               show_time, exit_minutes, shown_slot, exit_err
    );
endinterface

// File: rtl/parking_slot_manager.sv
// rtl/parking_slot_manager.sv - slot allocation, per-slot minute timers and indicator lights
module parking_slot_manager #(
    parameter int     NUM_SLOTS   = 8,
    parameter int     SLOT_W      = 4,
    parameter int     TIMER_W     = 16,
    parameter longint MINUTE_DIV  = 64'd2400000000,
    parameter longint BLINK_DIV   = 20000000,
    parameter int     FULL_PHASES = 12,
    parameter int     DOOR_PHASES = 20,
    parameter longint SHOW_CYCLES = 600000000
) (
    input  logic                  clk,
    input  logic                  reset,
    parking_slot_manager_if.slave bus
);
    localparam int PRE_W  = (MINUTE_DIV > 1) ? $clog2(MINUTE_DIV) : 1;
    localparam int BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SHW_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam int MAX_PH = (FULL_PHASES > DOOR_PHASES) ? FULL_PHASES : DOOR_PHASES;
    localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

    localparam logic [PRE_W-1:0]   PRE_LAST    = PRE_W'(MINUTE_DIV - 1);
    localparam logic [BLK_W-1:0]   BLK_LAST    = BLK_W'(BLINK_DIV - 1);
    localparam logic [SHW_W-1:0]   SHW_LAST    = SHW_W'(SHOW_CYCLES - 1);
    localparam logic [PH_W-1:0]    FULL_LAST   = PH_W'(FULL_PHASES - 1);
    localparam logic [PH_W-1:0]    DOOR_LAST   = PH_W'(DOOR_PHASES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;
    localparam logic [SLOT_W:0]    SLOTS_TOTAL = (SLOT_W+1)'(NUM_SLOTS);

    typedef enum logic [2:0] {
        IDLE, ALLOC, FULL_WAIT, RELEASE, SHOW_TIME, DOOR_WAIT
    } state_t;

    state_t state, state_next;

    logic                 entry_q, entry_h, entry_arm;
    logic                 exit_q, exit_h, exit_arm;
    logic [SLOT_W-1:0]    exit_slot_q;
    logic [SLOT_W-1:0]    cap_slot;
    logic                 entry_edge, exit_edge;

    logic [PRE_W-1:0]     pre;
    logic                 tick;
    logic [BLK_W-1:0]     blk_cnt;
    logic [PH_W-1:0]      phase;
    logic [SHW_W-1:0]     show_cnt;

    logic [NUM_SLOTS-1:0] occ;
    logic [SLOT_W:0]      free_cnt;
    logic [TIMER_W-1:0]   timer [NUM_SLOTS];
    logic [TIMER_W-1:0]   ex_min;
    logic [SLOT_W-1:0]    sh_slot;

    logic [SLOT_W-1:0]    free_idx;
    logic                 cap_occ;
    logic [TIMER_W-1:0]   cap_timer;
    logic                 do_alloc, do_release, capture;

    // A request needs the sensor to have been seen released since reset, so
    // a sensor already held low when reset lifts never counts as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q     <= 1'b1;
            entry_h     <= 1'b1;
            entry_arm   <= 1'b0;
            exit_q      <= 1'b1;
            exit_h      <= 1'b1;
            exit_arm    <= 1'b0;
            exit_slot_q <= '0;
        end else begin
            entry_q     <= bus.entry_sensor_n;
            entry_h     <= entry_q;
            entry_arm   <= entry_arm | bus.entry_sensor_n;
            exit_q      <= bus.exit_sensor_n;
            exit_h      <= exit_q;
            exit_arm    <= exit_arm | bus.exit_sensor_n;
            exit_slot_q <= bus.exit_slot;
        end
    end

    assign entry_edge = entry_arm & entry_h & ~entry_q;
    assign exit_edge  = exit_arm & exit_h & ~exit_q;
    assign tick       = (pre == PRE_LAST);

    // Free-running minute prescaler, independent of the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
        end
    end

    // Lowest free slot plus lookups of the slot captured for release; an
    // out-of-range slot matches no index and so reads as unoccupied.
    always_comb begin
        free_idx  = '0;
        cap_occ   = 1'b0;
        cap_timer = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) free_idx = SLOT_W'(i);
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (cap_slot == SLOT_W'(i)) begin
                cap_occ   = occ[i];
                cap_timer = timer[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, datapath strobes and light outputs.
    always_comb begin
        state_next     = state;
        do_alloc       = 1'b0;
        do_release     = 1'b0;
        capture        = 1'b0;
        bus.exit_err   = 1'b0;
        bus.full_light = 1'b0;
        bus.door_light = 1'b0;
        bus.show_time  = 1'b0;
        case (state)
            IDLE: begin
                if (exit_edge) begin
                    state_next = RELEASE;
                    capture    = 1'b1;
                end else if (entry_edge) begin
                    state_next = ALLOC;
                end
            end
            ALLOC: begin
                if (free_cnt == '0) begin
                    state_next = FULL_WAIT;
                end else begin
                    do_alloc   = 1'b1;
                    state_next = DOOR_WAIT;
                end
            end
            RELEASE: begin
                if (cap_occ) begin
                    do_release = 1'b1;
                    state_next = SHOW_TIME;
                end else begin
                    bus.exit_err = 1'b1;
                    state_next   = IDLE;
                end
            end
            SHOW_TIME: begin
                bus.show_time = 1'b1;
                if (show_cnt == SHW_LAST) state_next = DOOR_WAIT;
            end
            DOOR_WAIT: begin
                bus.door_light = ~phase[0];
                if (blk_cnt == BLK_LAST && phase == DOOR_LAST) state_next = IDLE;
            end
            FULL_WAIT: begin
                bus.full_light = ~phase[0];
                if (blk_cnt == BLK_LAST && phase == FULL_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Dwell counters restart on every state change so each wait starts at phase 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_cnt  <= '0;
            phase    <= '0;
            show_cnt <= '0;
        end else if (state_next != state) begin
            blk_cnt  <= '0;
            phase    <= '0;
            show_cnt <= '0;
        end else begin
            if (state == SHOW_TIME) show_cnt <= show_cnt + 1'b1;
            if (state == DOOR_WAIT || state == FULL_WAIT) begin
                if (blk_cnt == BLK_LAST) begin
                    blk_cnt <= '0;
                    phase   <= phase + 1'b1;
                end else begin
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end
        end
    end

    // Captured exit slot, taken when IDLE accepts an exit request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        cap_slot <= '0;
        else if (capture) cap_slot <= exit_slot_q;
    end

    // Occupancy, free count, per-slot timers and the latched exit report;
    // clearing a slot's timer takes precedence over a coincident minute tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ      <= '0;
            free_cnt <= SLOTS_TOTAL;
            ex_min   <= '0;
            sh_slot  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) timer[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if ((do_alloc && free_idx == SLOT_W'(i)) ||
                    (do_release && cap_slot == SLOT_W'(i))) begin
                    timer[i] <= '0;
                end else if (tick && occ[i] && timer[i] != TIMER_MAX) begin
                    timer[i] <= timer[i] + 1'b1;
                end
                if (do_alloc && free_idx == SLOT_W'(i))    occ[i] <= 1'b1;
                if (do_release && cap_slot == SLOT_W'(i)) occ[i] <= 1'b0;
            end
            if (do_alloc) free_cnt <= free_cnt - 1'b1;
            if (do_release) begin
                free_cnt <= free_cnt + 1'b1;
                ex_min   <= cap_timer;
                sh_slot  <= cap_slot;
            end
        end
    end

    assign bus.occupied     = occ;
    assign bus.free_count   = free_cnt;
    assign bus.next_slot    = free_idx;
    assign bus.exit_minutes = ex_min;
    assign bus.shown_slot   = sh_slot;
endmodule

// File: tb/tb_parking_slot_manager.sv
// tb/tb_parking_slot_manager.sv - self-checking bench for parking_slot_manager
module tb_parking_slot_manager;
    localparam int NS   = 4;
    localparam int SW   = 3;
    localparam int TW   = 4;
    localparam int MDIV = 10;
    localparam int BDIV = 2;
    localparam int FPH  = 4;
    localparam int DPH  = 4;
    localparam int SHOW = 8;
    localparam int TMAX = (1 << TW) - 1;
    localparam int VW   = NS + (SW + 1) + SW + 3 + TW + SW + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails = 0;

    parking_slot_manager_if #(.NUM_SLOTS(NS), .SLOT_W(SW), .TIMER_W(TW)) bus ();

    parking_slot_manager #(
        .NUM_SLOTS(NS), .SLOT_W(SW), .TIMER_W(TW), .MINUTE_DIV(MDIV),
        .BLINK_DIV(BDIV), .FULL_PHASES(FPH), .DOOR_PHASES(DPH), .SHOW_CYCLES(SHOW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: occupancy and minute counts per slot, plus a queue of
    // the light/show levels scheduled for the coming cycles.
    typedef struct packed {logic door; logic full; logic show;} sched_t;
    sched_t m_sched[$];
    bit     m_occ[NS];
    int     m_tmr[NS];
    int     m_pre, m_exmin, m_shslot, m_pending, m_pslot, m_fell_slot, m_act, m_hit;
    bit     m_err, m_prev_en, m_prev_ex, m_arm_en, m_arm_ex, m_fell_en, m_fell_ex;
    bit     m_was_idle, m_tick, m_ok;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sched.delete();
            for (int i = 0; i < NS; i++) begin m_occ[i] = 0; m_tmr[i] = 0; end
            m_pre = 0; m_exmin = 0; m_shslot = 0; m_pending = 0; m_pslot = 0;
            m_err = 0; m_prev_en = 1; m_prev_ex = 1; m_arm_en = 0; m_arm_ex = 0;
            m_fell_en = 0; m_fell_ex = 0; m_fell_slot = 0;
        end else begin
            m_was_idle = (m_pending == 0) && (m_sched.size() == 0);
            if (m_sched.size() > 0) void'(m_sched.pop_front());
            m_tick = (m_pre == MDIV - 1);
            m_pre  = m_tick ? 0 : m_pre + 1;
            m_err  = 0;
            m_act  = m_pending;
            m_pending = 0;
            m_ok = (m_pslot < NS) && m_occ[m_pslot % NS];
            if (m_act == 2 && m_ok) begin
                m_exmin = m_tmr[m_pslot];
                m_shslot = m_pslot;
            end
            if (m_tick)
                for (int i = 0; i < NS; i++)
                    if (m_occ[i] && m_tmr[i] < TMAX) m_tmr[i]++;
            if (m_act == 1) begin
                m_hit = -1;
                for (int i = 0; i < NS; i++) if (!m_occ[i] && m_hit < 0) m_hit = i;
                if (m_hit < 0) begin
                    for (int c = 0; c < FPH * BDIV; c++)
                        m_sched.push_back('{door: 1'b0, full: ((c / BDIV) % 2 == 0), show: 1'b0});
                end else begin
                    m_occ[m_hit] = 1; m_tmr[m_hit] = 0;
                    for (int c = 0; c < DPH * BDIV; c++)
                        m_sched.push_back('{door: ((c / BDIV) % 2 == 0), full: 1'b0, show: 1'b0});
                end
            end else if (m_act == 2 && m_ok) begin
                m_occ[m_pslot] = 0; m_tmr[m_pslot] = 0;
                for (int c = 0; c < SHOW; c++)
                    m_sched.push_back('{door: 1'b0, full: 1'b0, show: 1'b1});
                for (int c = 0; c < DPH * BDIV; c++)
                    m_sched.push_back('{door: ((c / BDIV) % 2 == 0), full: 1'b0, show: 1'b0});
            end
            if (m_was_idle && m_fell_ex) begin
                m_pending = 2; m_pslot = m_fell_slot;
                m_err = !((m_pslot < NS) && m_occ[m_pslot % NS]);
            end else if (m_was_idle && m_fell_en) begin
                m_pending = 1;
            end
            m_fell_en   = m_arm_en && m_prev_en && !bus.entry_sensor_n;
            m_fell_ex   = m_arm_ex && m_prev_ex && !bus.exit_sensor_n;
            m_fell_slot = int'(bus.exit_slot);
            m_arm_en    = m_arm_en | bus.entry_sensor_n;
            m_arm_ex    = m_arm_ex | bus.exit_sensor_n;
            m_prev_en   = bus.entry_sensor_n;
            m_prev_ex   = bus.exit_sensor_n;
        end
    end

    function automatic bit m_idle();
        return (m_pending == 0) && (m_sched.size() == 0) && !m_fell_en && !m_fell_ex;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [NS-1:0] o;
        int free, nxt;
        sched_t s;
        free = 0; nxt = -1; o = '0;
        for (int i = 0; i < NS; i++) begin
            o[i] = m_occ[i];
            if (!m_occ[i]) begin free++; if (nxt < 0) nxt = i; end
        end
        if (nxt < 0) nxt = 0;
        s = (m_sched.size() > 0) ? m_sched[0] : sched_t'(3'b000);
        return {o, (SW+1)'(free), SW'(nxt), s.full, s.door, s.show,
                TW'(m_exmin), SW'(m_shslot), m_err};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.occupied, bus.free_count, bus.next_slot, bus.full_light, bus.door_light,
                bus.show_time, bus.exit_minutes, bus.shown_slot, bus.exit_err};
    endfunction

    task automatic press(input bit en, input bit ex, input int slot);
        bus.entry_sensor_n = !en;
        bus.exit_sensor_n  = !ex;
        bus.exit_slot      = SW'(slot);
        @(negedge clk);
        bus.entry_sensor_n = 1'b1;
        bus.exit_sensor_n  = 1'b1;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (m_idle()) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.entry_sensor_n = 1'b1; bus.exit_sensor_n = 1'b1; bus.exit_slot = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.free_count !== 4'd4) begin
            fails++; $display("FAIL reset_free_count got=%0d exp=4", bus.free_count);
        end
        checks++;
        if (dut_vec() !== {4'b0, 4'd4, {(VW-8){1'b0}}}) begin
            fails++; $display("FAIL reset_outputs got=%0h exp=%0h", dut_vec(), {4'b0, 4'd4, {(VW-8){1'b0}}});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        bit found, to;
        logic [7:0] pat;
        for (int k = 0; k < 4; k++) begin
            press(1, 0, 0);
            found = 0;
            for (int c = 0; c < 12 && !found; c++) begin
                @(negedge clk);
                if (bus.door_light) found = 1;
            end
            pat[7] = bus.door_light;
            for (int j = 6; j >= 0; j--) begin @(negedge clk); pat[j] = bus.door_light; end
            checks++;
            if (pat !== 8'b1100_1100) begin
                fails++; $display("FAIL fill_door_pattern entry=%0d got=%b exp=11001100", k, pat);
            end
            @(negedge clk);
            checks++;
            if (bus.door_light !== 1'b0) begin
                fails++; $display("FAIL fill_door_off entry=%0d got=%b exp=0", k, bus.door_light);
            end
            wait_idle(to);
            checks++;
            if (to || bus.occupied !== 4'((1 << (k + 1)) - 1) || bus.free_count !== 4'(3 - k)) begin
                fails++;
                $display("FAIL fill_occupancy entry=%0d got=%b/%0d exp=%b/%0d timeout=%0d",
                         k, bus.occupied, bus.free_count, 4'((1 << (k + 1)) - 1), 3 - k, to);
            end
        end
    endtask

    task automatic test_full();
        bit found, to;
        logic [7:0] pat;
        press(1, 0, 0);
        found = 0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clk);
            if (bus.full_light) found = 1;
        end
        pat[7] = bus.full_light;
        for (int j = 6; j >= 0; j--) begin @(negedge clk); pat[j] = bus.full_light; end
        checks++;
        if (pat !== 8'b1100_1100) begin
            fails++; $display("FAIL full_light_pattern got=%b exp=11001100", pat);
        end
        @(negedge clk);
        checks++;
        if ({bus.full_light, bus.door_light, bus.show_time, bus.occupied, bus.free_count, bus.next_slot}
            !== {3'b000, 4'b1111, 4'd0, 3'd0}) begin
            fails++;
            $display("FAIL full_after got=%b%b%b occ=%b free=%0d next=%0d exp=000 occ=1111 free=0 next=0",
                     bus.full_light, bus.door_light, bus.show_time, bus.occupied, bus.free_count, bus.next_slot);
        end
        checks++;
        if (!m_idle()) begin
            fails++; $display("FAIL full_return_idle got=busy exp=idle");
        end
        wait_idle(to);
    endtask

    task automatic test_timer();
        bit to, found;
        int cnt;
        do_reset();
        press(1, 0, 0);
        wait_idle(to);
        for (int c = 0; c < 20; c++) begin
            if (m_pre == 7) break;
            @(negedge clk);
        end
        bus.entry_sensor_n = 1'b0;
        @(negedge clk);
        bus.entry_sensor_n = 1'b1;
        repeat (2) @(posedge clk);
        repeat (32) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.occupied !== 4'b0011) begin
            fails++; $display("FAIL timer_setup got=%b exp=0011", bus.occupied);
        end
        bus.exit_sensor_n = 1'b0; bus.exit_slot = 3'd1;
        @(negedge clk);
        bus.exit_sensor_n = 1'b1;
        found = 0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk);
            if (bus.show_time) found = 1;
        end
        checks++;
        if (!found || bus.exit_minutes !== 4'd3 || bus.shown_slot !== 3'd1 || bus.occupied[1] !== 1'b0) begin
            fails++;
            $display("FAIL timer_exit got=min%0d slot%0d occ%b show%0d exp=min3 slot1 occ1=0 show1",
                     bus.exit_minutes, bus.shown_slot, bus.occupied, found);
        end
        cnt = 0;
        while (bus.show_time && cnt < 20) begin cnt++; @(negedge clk); end
        checks++;
        if (cnt !== 8 || bus.door_light !== 1'b1) begin
            fails++; $display("FAIL timer_show_len got=%0d door=%b exp=8 door=1", cnt, bus.door_light);
        end
        checks++;
        if (bus.exit_minutes !== 4'd3 || bus.shown_slot !== 3'd1) begin
            fails++; $display("FAIL timer_hold got=%0d/%0d exp=3/1", bus.exit_minutes, bus.shown_slot);
        end
        wait_idle(to);
    endtask

    task automatic test_bad_exit();
        bit to;
        int errs;
        int slots[2] = '{2, 5};
        foreach (slots[s]) begin
            press(0, 1, slots[s]);
            errs = 0;
            repeat (6) begin @(negedge clk); if (bus.exit_err) errs++; end
            checks++;
            if (errs !== 1) begin
                fails++; $display("FAIL bad_exit_pulse slot=%0d got=%0d exp=1", slots[s], errs);
            end
            checks++;
            if (bus.occupied !== 4'b0001 || bus.free_count !== 4'd3 || bus.show_time !== 1'b0) begin
                fails++;
                $display("FAIL bad_exit_nochange slot=%0d got=%b/%0d exp=0001/3", slots[s], bus.occupied, bus.free_count);
            end
            wait_idle(to);
        end
    endtask

    task automatic test_simultaneous();
        bit to;
        press(1, 1, 0);
        wait_idle(to);
        checks++;
        if (to || bus.occupied !== 4'b0000 || bus.free_count !== 4'd4 || bus.shown_slot !== 3'd0) begin
            fails++;
            $display("FAIL simul_release got=%b/%0d slot%0d exp=0000/4 slot0", bus.occupied, bus.free_count, bus.shown_slot);
        end
        press(1, 0, 0);
        wait_idle(to);
        checks++;
        if (to || bus.occupied !== 4'b0001) begin
            fails++; $display("FAIL simul_realloc got=%b exp=0001", bus.occupied);
        end
    endtask

    task automatic test_reset_mid();
        bit to, seen;
        press(1, 0, 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.door_light) break;
        end
        bus.entry_sensor_n = 1'b0; bus.exit_sensor_n = 1'b0; bus.exit_slot = 3'd0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== {4'b0, 4'd4, {(VW-8){1'b0}}}) begin
            fails++; $display("FAIL reset_mid_outputs got=%0h exp=%0h", dut_vec(), {4'b0, 4'd4, {(VW-8){1'b0}}});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.occupied != 0 || bus.door_light || bus.exit_err || bus.show_time) seen = 1;
        end
        checks++;
        if (seen) begin
            fails++; $display("FAIL reset_mid_no_alloc got=activity exp=none occ=%b", bus.occupied);
        end
        bus.entry_sensor_n = 1'b1; bus.exit_sensor_n = 1'b1;
        repeat (2) @(negedge clk);
        press(1, 0, 0);
        wait_idle(to);
        checks++;
        if (to || bus.occupied !== 4'b0001) begin
            fails++; $display("FAIL reset_mid_fresh_edge got=%b exp=0001", bus.occupied);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 9) == 0) bus.entry_sensor_n = ~bus.entry_sensor_n;
            if ($urandom_range(0, 6) == 0) begin
                bus.exit_sensor_n = ~bus.exit_sensor_n;
                if (!bus.exit_sensor_n) bus.exit_slot = SW'($urandom_range(0, 5));
            end
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                fails++; $display("FAIL random_cycle%0d got=%0h exp=%0h", c, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full();
        test_timer();
        test_bad_exit();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
